// File: rtl/lightgun_arbiter.sv
// lightgun_arbiter
// Arbitrates light-gun hit pulses from up to two guns into a single PPU
// H/V counter latch request. One gun is armed per frame; the first accepted
// hit of the frame drives PPU_LATCH_N low for HOLD_LEN cycles, and a frame
// that ends without a hit flags a sticky MISS for the armed gun.
//
// Optional build macro: LIGHTGUN_ARB_DEBOUNCE_EN
//   When defined, a falling edge on the active gun input is accepted only
//   after the sampled level has been low for two consecutive cycles, which
//   filters single-cycle glitches at the cost of one extra cycle of latency.
module lightgun_arbiter #(
  parameter logic [7:0] HOLD_LEN = 8'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VDE,
  input  logic       P6_A,
  input  logic       P6_B,
  input  logic       EN_B,
  input  logic       ALT,
  output logic       PPU_LATCH_N,
  output logic       LATCH_STB,
  output logic       GUN_SEL,
  output logic [1:0] MISS,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Edge helpers on sampled (registered) levels.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic fall_edge(input logic cur, input logic prev);
    return prev & ~cur;
  endfunction

  // Input sample registers and their one-cycle-delayed copies.
  logic vde_q, vde_dly_q;
  logic p6a_q, p6a_dly_q;
  logic p6b_q, p6b_dly_q;
`ifdef LIGHTGUN_ARB_DEBOUNCE_EN
  logic p6a_dly2_q, p6b_dly2_q;
`endif

  // FSM and output registers.
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       latch_n_q, latch_n_d;
  logic       stb_q, stb_d;
  logic       gun_sel_q, gun_sel_d;
  logic [1:0] miss_q, miss_d;

  logic frame_start_s;
  logic frame_end_s;
  logic p6_act_s;
  logic p6_act_dly_s;
  logic hit_s;

  // Sample asynchronous-ish inputs once; all decisions use these copies.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vde_q      <= 1'b0;
      vde_dly_q  <= 1'b0;
      p6a_q      <= 1'b1;
      p6a_dly_q  <= 1'b1;
      p6b_q      <= 1'b1;
      p6b_dly_q  <= 1'b1;
`ifdef LIGHTGUN_ARB_DEBOUNCE_EN
      p6a_dly2_q <= 1'b1;
      p6b_dly2_q <= 1'b1;
`endif
    end else begin
      vde_q      <= VDE;
      vde_dly_q  <= vde_q;
      p6a_q      <= P6_A;
      p6a_dly_q  <= p6a_q;
      p6b_q      <= P6_B;
      p6b_dly_q  <= p6b_q;
`ifdef LIGHTGUN_ARB_DEBOUNCE_EN
      p6a_dly2_q <= p6a_dly_q;
      p6b_dly2_q <= p6b_dly_q;
`endif
    end
  end

  assign frame_start_s = rise_edge(vde_q, vde_dly_q);
  assign frame_end_s   = fall_edge(vde_q, vde_dly_q);

  // Only the gun armed for this frame can produce a hit.
  assign p6_act_s     = gun_sel_q ? p6b_q     : p6a_q;
  assign p6_act_dly_s = gun_sel_q ? p6b_dly_q : p6a_dly_q;

`ifdef LIGHTGUN_ARB_DEBOUNCE_EN
  logic p6_act_dly2_s;
  assign p6_act_dly2_s = gun_sel_q ? p6b_dly2_q : p6a_dly2_q;
  // High followed by two consecutive low samples.
  assign hit_s = fall_edge(p6_act_dly_s, p6_act_dly2_s) & ~p6_act_s;
`else
  assign hit_s = fall_edge(p6_act_s, p6_act_dly_s);
`endif

  // State, counter and registered-output update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      latch_n_q <= 1'b1;
      stb_q     <= 1'b0;
      gun_sel_q <= 1'b0;
      miss_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latch_n_q <= latch_n_d;
      stb_q     <= stb_d;
      gun_sel_q <= gun_sel_d;
      miss_q    <= miss_d;
    end
  end

  // Next-state logic: frame start overrides everything, including HOLD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_n_d = 1'b1;
    stb_d     = 1'b0;
    gun_sel_d = gun_sel_q;
    miss_d    = miss_q;

    if (frame_start_s) begin
      state_d   = ST_ARMED;
      cnt_d     = 8'd0;
      gun_sel_d = (ALT & EN_B) ? ~gun_sel_q : 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          // A hit beats a coincident frame end.
          if (hit_s) begin
            state_d           = ST_HOLD;
            cnt_d             = HOLD_LEN;
            latch_n_d         = 1'b0;
            stb_d             = 1'b1;
            miss_d[gun_sel_q] = 1'b0;
          end else if (frame_end_s) begin
            state_d           = ST_IDLE;
            miss_d[gun_sel_q] = 1'b1;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_HOLD: begin
          // cnt_q counts the low cycles still owed, including this one.
          if (cnt_q <= 8'd1) begin
            state_d = ST_DONE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d     = cnt_q - 8'd1;
            latch_n_d = 1'b0;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  assign PPU_LATCH_N = latch_n_q;
  assign LATCH_STB   = stb_q;
  assign GUN_SEL     = gun_sel_q;
  assign MISS        = miss_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_lightgun_arbiter.sv
// Directed testbench for lightgun_arbiter. Two instances share stimulus:
// one with HOLD_LEN=4 and one with HOLD_LEN=255 for the long-hold abort case.
module tb_lightgun_arbiter;

  logic CLK = 1'b0;
  logic RESET, VDE, P6_A, P6_B, EN_B, ALT;
  logic latch4, stb4, gun4;
  logic [1:0] miss4, st4;
  logic latch255, stb255, gun255;
  logic [1:0] miss255, st255;

  int n_checks = 0;
  int n_fail   = 0;
  int first_low, low_cnt, stb_cnt;

`ifdef LIGHTGUN_ARB_DEBOUNCE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  always #5 CLK = ~CLK;

  lightgun_arbiter #(.HOLD_LEN(8'd4)) dut4 (
    .CLK(CLK), .RESET(RESET), .VDE(VDE), .P6_A(P6_A), .P6_B(P6_B),
    .EN_B(EN_B), .ALT(ALT), .PPU_LATCH_N(latch4), .LATCH_STB(stb4),
    .GUN_SEL(gun4), .MISS(miss4), .STATE(st4)
  );

  lightgun_arbiter #(.HOLD_LEN(8'd255)) dut255 (
    .CLK(CLK), .RESET(RESET), .VDE(VDE), .P6_A(P6_A), .P6_B(P6_B),
    .EN_B(EN_B), .ALT(ALT), .PPU_LATCH_N(latch255), .LATCH_STB(stb255),
    .GUN_SEL(gun255), .MISS(miss255), .STATE(st255)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; VDE = 1'b0; P6_A = 1'b1; P6_B = 1'b1;
    step(3);
    RESET = 1'b0;
    step(1);
  endtask

  task automatic frame_start();
    VDE = 1'b1;
    step(2);
  endtask

  task automatic frame_end();
    VDE = 1'b0;
    step(2);
  endtask

  // Drive one gun low for 'rel' cycles, observe dut4 for 14 cycles.
  task automatic hit_window(input bit use_b, input int rel,
                            output int fl, output int lc, output int sc);
    fl = 0; lc = 0; sc = 0;
    if (use_b) P6_B = 1'b0;
    else       P6_A = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step(1);
      if (latch4 == 1'b0) begin
        if (fl == 0) fl = i;
        lc++;
      end
      if (stb4) sc++;
      if (i == rel) begin
        P6_A = 1'b1;
        P6_B = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    EN_B = 1'b0; ALT = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_state", st4, 2'd0);
    check_eq("rst_latch", latch4, 1'b1);
    check_eq("rst_stb", stb4, 1'b0);
    check_eq("rst_gun", gun4, 1'b0);
    check_eq("rst_miss", miss4, 2'b00);

    // Single gun, mid-frame hit: latency, hold length, one strobe, DONE
    frame_start();
    check_eq("a_armed", st4, 2'd1);
    check_eq("a_gun", gun4, 1'b0);
    step(5);
    hit_window(1'b0, 3, first_low, low_cnt, stb_cnt);
    check_eq("a_latency", first_low, LAT);
    check_eq("a_lowcnt", low_cnt, 4);
    check_eq("a_stbcnt", stb_cnt, 1);
    check_eq("a_done", st4, 2'd3);
    check_eq("a_miss", miss4, 2'b00);

    // Second pulse 100 cycles after the first is ignored in DONE
    step(100 - 14);
    hit_window(1'b0, 3, first_low, low_cnt, stb_cnt);
    check_eq("dup_stb", stb_cnt, 0);
    check_eq("dup_low", low_cnt, 0);
    check_eq("dup_state", st4, 2'd3);
    frame_end();
    check_eq("done_fend_state", st4, 2'd3);
    check_eq("done_fend_miss", miss4, 2'b00);

    // Alternating guns; gun A is inactive in a GUN_SEL=1 frame
    do_reset();
    ALT = 1'b1; EN_B = 1'b1;
    frame_start();
    check_eq("alt_gun1", gun4, 1'b1);
    hit_window(1'b0, 3, first_low, low_cnt, stb_cnt);
    check_eq("alt_inact_stb", stb_cnt, 0);
    check_eq("alt_inact_low", low_cnt, 0);
    check_eq("alt_inact_state", st4, 2'd1);
    frame_end();
    check_eq("alt_miss_b", miss4, 2'b10);
    check_eq("alt_idle", st4, 2'd0);
    frame_start();
    check_eq("alt_gun2", gun4, 1'b0);
    frame_end();
    check_eq("alt_miss_ab", miss4, 2'b11);
    frame_start();
    check_eq("alt_gun3", gun4, 1'b1);
    hit_window(1'b1, 3, first_low, low_cnt, stb_cnt);
    check_eq("b_hit_stb", stb_cnt, 1);
    check_eq("b_hit_miss", miss4, 2'b01);

    // EN_B dropped mid-frame only matters at the next frame start
    EN_B = 1'b0;
    step(3);
    check_eq("enb_hold_gun", gun4, 1'b1);
    frame_end();
    frame_start();
    check_eq("enb_gun_a", gun4, 1'b0);
    frame_end();
    frame_start();
    check_eq("enb_gun_a_again", gun4, 1'b0);

    // P6 already low at frame start is not a hit; a fresh edge is
    do_reset();
    ALT = 1'b0;
    P6_A = 1'b0;
    frame_start();
    step(3);
    check_eq("prelow_state", st4, 2'd1);
    P6_A = 1'b1;
    step(2);
    hit_window(1'b0, 3, first_low, low_cnt, stb_cnt);
    check_eq("prelow_then_hit", stb_cnt, 1);

    // Single low sample: accepted plainly, discarded with debounce
    do_reset();
    frame_start();
    hit_window(1'b0, 1, first_low, low_cnt, stb_cnt);
`ifdef LIGHTGUN_ARB_DEBOUNCE_EN
    check_eq("glitch_stb", stb_cnt, 0);
    check_eq("glitch_state", st4, 2'd1);
`else
    check_eq("glitch_stb", stb_cnt, 1);
    check_eq("glitch_latency", first_low, 2);
`endif

    // Two-cycle low: latency LAT
    do_reset();
    frame_start();
    hit_window(1'b0, 2, first_low, low_cnt, stb_cnt);
    check_eq("low2_latency", first_low, LAT);
    check_eq("low2_stb", stb_cnt, 1);

`ifndef LIGHTGUN_ARB_DEBOUNCE_EN
    // Hit coinciding with frame end: hit wins
    do_reset();
    frame_start();
    VDE = 1'b0; P6_A = 1'b0;
    step(2);
    check_eq("coinc_state", st4, 2'd2);
    check_eq("coinc_miss", miss4, 2'b00);
    check_eq("coinc_stb", stb4, 1'b1);
    P6_A = 1'b1;
`endif

    // Long hold aborted by next frame start, then a new hit
    do_reset();
    frame_start();
    P6_A = 1'b0;
    step(LAT);
    check_eq("long_low", latch255, 1'b0);
    check_eq("long_hold", st255, 2'd2);
    P6_A = 1'b1;
    step(10);
    check_eq("long_still_low", latch255, 1'b0);
    VDE = 1'b0;
    step(1);
    frame_start();
    check_eq("abort_state", st255, 2'd1);
    check_eq("abort_latch", latch255, 1'b1);
    P6_A = 1'b0;
    step(LAT);
    check_eq("rehit_stb", stb255, 1'b1);
    check_eq("rehit_low", latch255, 1'b0);
    P6_A = 1'b1;

    // Reset during HOLD with nonzero GUN_SEL and MISS
    do_reset();
    ALT = 1'b1; EN_B = 1'b1;
    frame_start();
    frame_end();
    frame_start();
    frame_end();
    frame_start();
    P6_B = 1'b0;
    step(LAT);
    check_eq("prerst_low", latch4, 1'b0);
    check_eq("prerst_gun", gun4, 1'b1);
    check_eq("prerst_miss", miss4, 2'b01);
    RESET = 1'b1;
    step(1);
    check_eq("hrst_latch", latch4, 1'b1);
    check_eq("hrst_state", st4, 2'd0);
    check_eq("hrst_gun", gun4, 1'b0);
    check_eq("hrst_miss", miss4, 2'b00);
    RESET = 1'b0;
    P6_B = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lightgun_arbiter.md
LIGHTGUN_ARBITER -- requirements
Module: lightgun_arbiter

Interface
REQ-001 Parameter HOLD_LEN, default 8'd4, sets how many CLK cycles PPU_LATCH_N is held low per accepted hit (legal range 1..255).
REQ-002 CLK  input  1  system clock.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 VDE  input  1  vertical display enable; rising edge = frame start, falling edge = frame end.
REQ-005 P6_A  input  1  gun A hit pulse, active-low.
REQ-006 P6_B  input  1  gun B hit pulse, active-low.
REQ-007 EN_B  input  1  gun B present.
REQ-008 ALT  input  1  1 = alternate guns per frame, 0 = gun A only.
REQ-009 PPU_LATCH_N  output  1  PPU H/V counter latch request, active-low.
REQ-010 LATCH_STB  output  1  one-CLK pulse on each accepted hit.
REQ-011 GUN_SEL  output  1  gun armed in the current frame (0 = A, 1 = B).
REQ-012 MISS  output  2  per-gun sticky no-hit flag; bit0 = A, bit1 = B.
REQ-013 STATE  output  2  FSM state: 0 IDLE, 1 ARMED, 2 HOLD, 3 DONE.

Function
REQ-014 VDE, P6_A and P6_B shall each be sampled once into a register before any use; all edge detection operates on these sampled values.
REQ-015 Frame start (sampled VDE 0->1) shall move the FSM to ARMED from any state, including aborting HOLD with PPU_LATCH_N released that same cycle.
REQ-016 At frame start, GUN_SEL shall toggle if ALT=1 and EN_B=1; otherwise it shall be forced to 0.
REQ-017 The active P6 shall be the sampled P6 of the gun selected by the GUN_SEL value in effect after the frame-start update.
REQ-018 In ARMED, a 1->0 transition of the active P6 shall be an accepted hit, moving to HOLD on the next cycle.
REQ-019 Each accepted hit shall assert LATCH_STB for exactly one cycle.
REQ-020 Each accepted hit shall drive PPU_LATCH_N low starting the same cycle as LATCH_STB.
REQ-021 Each accepted hit shall clear MISS[GUN_SEL].
REQ-022 Latency from the raw P6 falling edge to PPU_LATCH_N low shall be 2 CLK: 1 for the input register, 1 for the registered output.
REQ-023 HOLD shall keep PPU_LATCH_N low for exactly HOLD_LEN cycles using an 8-bit down-counter, then move to DONE.
REQ-024 In DONE, every P6 edge shall be ignored, so at most one hit is accepted per frame.
REQ-025 A frame end (sampled VDE 1->0) while ARMED shall set MISS[GUN_SEL] and move to IDLE.
REQ-026 A frame end while in HOLD or DONE shall not change state or counter; HOLD runs to completion, then the FSM enters DONE.
REQ-027 The P6 of the inactive gun shall never affect PPU_LATCH_N, LATCH_STB or MISS.
REQ-028 A P6 already low at frame start shall not count as a hit; a 1->0 transition is required.
REQ-029 If a hit and frame end coincide in ARMED, the hit shall win: MISS is not set and the FSM moves to HOLD.
REQ-030 Deasserting EN_B mid-frame shall take effect only at the next frame start.

Reset
REQ-031 While RESET=1 the following shall hold: STATE=IDLE, PPU_LATCH_N=1, LATCH_STB=0, GUN_SEL=0, MISS=2'b00, hold counter=0, input sample registers=1 (P6) and 0 (VDE).
REQ-032 Reset asserted during HOLD shall release PPU_LATCH_N on the next CLK edge.

Configuration
REQ-033 With LIGHTGUN_ARB_DEBOUNCE_EN defined, an active-P6 1->0 transition shall be accepted only if the sampled P6 stays low for 2 consecutive cycles, adding 1 CLK to the REQ-022 latency.
REQ-034 With LIGHTGUN_ARB_DEBOUNCE_EN defined, a 1-cycle low glitch shall be discarded and the FSM shall stay ARMED.
REQ-035 Without LIGHTGUN_ARB_DEBOUNCE_EN, a single sampled low cycle after a high cycle shall be accepted.

Verification
REQ-036 Bench shall cover: ALT=0, HOLD_LEN=4, P6_A pulse mid-frame -> PPU_LATCH_N low 2 CLK after the raw edge for exactly 4 cycles, one LATCH_STB, then STATE=3.
REQ-037 Bench shall cover: ALT=1, EN_B=1, three frames -> GUN_SEL 1,0,1; a P6_A pulse in a GUN_SEL=1 frame gives no latch, and that frame's end sets MISS=2'b10.
REQ-038 Bench shall cover: two P6_A pulses 100 cycles apart in one frame -> exactly one LATCH_STB; the second pulse is ignored in DONE.
REQ-039 Bench shall cover: HOLD_LEN=255, next frame start 10 cycles into HOLD -> PPU_LATCH_N released at that frame start, STATE=1, and a new hit is accepted.
REQ-040 Bench shall cover: RESET pulsed during HOLD -> PPU_LATCH_N=1 next cycle, STATE=0, GUN_SEL=0, MISS=0.
REQ-041 Bench shall cover: with LIGHTGUN_ARB_DEBOUNCE_EN, a 1-cycle P6 glitch -> no LATCH_STB; a 2-cycle low -> PPU_LATCH_N low 3 CLK after the raw edge.
